jk_excitation_driver: RTL and testbench
=======================================

# jk_excitation_driver

- Drives a bank of WIDTH master-slave JK flip-flops from a requested target state, which is the opposite direction to the flip-flop itself.
- Takes a target vector and the bank's current Q, computes per-bit J/K from the JK excitation table, and sequences one master-slave clock pulse (cp high, then cp low).
- Reports completion, and optionally checks the resulting state.
- Sits between a controller that issues state requests and the flip-flop bank under test or in use.

## Interface
Parameters:
- WIDTH, 4, number of flip-flops driven.
- PULSE_CYCLES, 2, clk cycles for each cp phase (high, then low); minimum 1.
- DC_FILL, 0, value placed on excitation don't-care inputs: 0 gives set/reset style, 1 gives toggle style.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_target  in  WIDTH  desired next Q of the bank.
- q_fb  in  WIDTH  current Q of the bank, already synchronous to clk.
- jk_j  out  WIDTH  J inputs to the bank.
- jk_k  out  WIDTH  K inputs to the bank.
- jk_cp  out  1  master-slave clock pulse to the bank.
- busy  out  1  a request is in progress (state is not IDLE).
- done  out  1  one-cycle pulse marking the end of a request.
- err  out  1  verify mismatch; pulses in the same cycle as done.

## Operation
- Accept: a request is accepted when req_valid && req_ready. In that cycle the block latches req_target into t and q_fb into q.
- Excitation, per bit:
  - DC_FILL=0: j = ~q & t, k = q & ~t.
  - DC_FILL=1: j = q | t, k = ~(q & t).
  - In both cases the bank's post-pulse Q equals t.
- FSM states: IDLE, SETUP, CP_HI, CP_LO, CHECK (verify build only), DONE.
- Transitions:
  - IDLE -> SETUP on accept.
  - SETUP -> CP_HI after 1 cycle.
  - CP_HI -> CP_LO after PULSE_CYCLES cycles.
  - CP_LO -> CHECK (verify build) or DONE (otherwise) after PULSE_CYCLES cycles.
  - CHECK -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle.
- Outputs by state:
  - jk_j/jk_k are driven with the excitation in SETUP and CP_HI, and are 0 in every other state.
  - jk_cp = 1 only in CP_HI.
  - req_ready = 1 only in IDLE.
  - busy = 1 in every state except IDLE.
  - done = 1 only in DONE.
- A phase counter (width $clog2(PULSE_CYCLES+1)) clears on every state entry. No wrap is possible because the counter is compared with PULSE_CYCLES-1.
- Boundary conditions:
  - req_valid while busy is ignored and not queued.
  - t == q still runs the full sequence and completes normally.
  - req_valid held high: the next request is accepted in the first IDLE cycle after DONE.
  - Changes on q_fb after accept have no effect on jk_j/jk_k.

## Timing
- Accept in cycle 0.
- SETUP in cycle 1.
- CP_HI in cycles 2..1+P, CP_LO in cycles 2+P..1+2P, where P = PULSE_CYCLES.
- Non-verify build: done in cycle 2+2P.
- Verify build: CHECK in cycle 2+2P, done in cycle 3+2P.
- J/K are stable for one full cycle before jk_cp rises and for the whole time jk_cp is high. They drop to 0 together with jk_cp falling.
- Reset values: state IDLE, jk_cp=0, jk_j=jk_k=0, done=0, err=0, busy=0. req_ready is 1 as soon as rst_n is high.
- Reset asserted mid-operation forces these values immediately, including jk_cp low. No done is produced for the aborted request.

## Configuration
- Macro JK_EXC_DRIVER_VERIFY_EN.
- Defined:
  - CHECK state is compiled in and samples q_fb.
  - q_fb != t sets err=1 in the DONE cycle; otherwise err=0.
  - err is not sticky.
- Undefined:
  - No CHECK state; err is tied to 0.
  - Latency shortens by one cycle.

## Structure
- Package jk_exc_pkg holds:
  - the state enum type;
  - the excitation function jk_excite(q, t, dc) returning {j, k};
  - constant DEFAULT_PULSE_CYCLES = 2.
- One sub-module, jk_phase_timer: the phase counter with load on state entry, producing a phase_last flag.

## Test plan
Settings for all scenarios: WIDTH=4, P=2, DC_FILL=0, non-verify build unless stated.
- Reset: hold rst_n=0 -> all outputs 0; after release, req_ready=1 and busy=0.
- Request with q_fb=0011, req_target=0101 ->
  - jk_j=0100 and jk_k=0010 in cycles 1-3, 0 from cycle 4;
  - jk_cp=1 in cycles 2-3;
  - done pulses in cycle 6.
- Same request with DC_FILL=1 -> jk_j=0111, jk_k=1110.
- req_valid held high with two targets -> second accept in cycle 7; req_valid during cycles 1-6 produces no effect.
- Verify build, bench model forces q_fb=0100 after the pulse for target 0101 -> done and err=1 in cycle 7. With a correct model -> err=0.
- rst_n pulsed low in cycle 3 (during CP_HI) -> jk_cp and jk_j/jk_k drop to 0 asynchronously, no done, and a new request is accepted normally afterwards.

Source files
------------

// File: rtl/jk_exc_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM state type and the
// per-bit JK excitation function.
package jk_exc_pkg;

  localparam int unsigned DEFAULT_PULSE_CYCLES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCpHi,
    StCpLo,
    StCheck,
    StDone
  } jk_state_e;

  // Returns {j, k} that move a JK flip-flop from q to t; dc selects the value
  // placed on the don't-care input (0: set/reset style, 1: toggle style).
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    logic j;
    logic k;
    if (dc) begin
      j = q | t;
      k = ~(q & t);
    end else begin
      j = ~q & t;
      k = q & ~t;
    end
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_phase_timer.sv
// Phase counter for the cp high/low phases: cleared on every state entry and
// saturating at PULSE_CYCLES-1, where phase_last is raised.
module jk_phase_timer #(
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic phase_last
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PULSE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  assign phase_last = (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (!phase_last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of master-slave JK flip-flops to a requested target state with one cp pulse.
// Define JK_EXC_DRIVER_VERIFY_EN to add a post-pulse check of q_fb reported on err.
module jk_excitation_driver
  import jk_exc_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
  parameter bit          DC_FILL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_cp,
  output logic             busy,
  output logic             done,
  output logic             err
);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] j_q, k_q, exc_j, exc_k;
  logic             cp_q, busy_q, done_q;
  logic             accept, phase_last;

  // Gated with rst_n so ready reads 0 while the block is held in reset.
  assign req_ready = rst_n && (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {exc_j[i], exc_k[i]} = jk_excite(q_fb[i], req_target[i], DC_FILL);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: state_d = StCpHi;
      StCpHi:  if (phase_last) state_d = StCpLo;
`ifdef JK_EXC_DRIVER_VERIFY_EN
      StCpLo:  if (phase_last) state_d = StCheck;
`else
      StCpLo:  if (phase_last) state_d = StDone;
`endif
      StCheck: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  jk_phase_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_d != state_q),
    .phase_last(phase_last)
  );

  // Outputs are registered from the next state so cp and J/K are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      k_q     <= '0;
      cp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cp_q    <= (state_d == StCpHi);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      if (accept) begin
        j_q <= exc_j;
        k_q <= exc_k;
      end else if (state_d != StSetup && state_d != StCpHi) begin
        j_q <= '0;
        k_q <= '0;
      end
    end
  end

`ifdef JK_EXC_DRIVER_VERIFY_EN
  logic [WIDTH-1:0] t_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) t_q <= req_target;
      err_q <= (state_q == StCheck) && (q_fb != t_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign jk_j  = j_q;
  assign jk_k  = k_q;
  assign jk_cp = cp_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: set/reset-style and toggle-style instances share stimulus
// and are checked cycle by cycle against a timing/excitation-table model and a JK bank model.
module tb_jk_excitation_driver;

  localparam int P = 2;
`ifdef JK_EXC_DRIVER_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif
  localparam int L = 2 + 2 * P + V;

  logic       clk, rst_n, req_valid;
  logic [3:0] req_target, q_fb;
  logic       ready0, cp0, busy0, done0, err0;
  logic       ready1, cp1, busy1, done1, err1;
  logic [3:0] j0, k0, j1, k1;
  logic [4:0] ctrl0, ctrl1;
  logic [15:0] jkv;

  int checks = 0;
  int errors = 0;

  assign ctrl0 = {ready0, busy0, cp0, done0, err0};
  assign ctrl1 = {ready1, busy1, cp1, done1, err1};
  assign jkv   = {j0, k0, j1, k1};

  jk_excitation_driver #(.WIDTH(4), .PULSE_CYCLES(P), .DC_FILL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
    .req_target(req_target), .q_fb(q_fb), .jk_j(j0), .jk_k(k0), .jk_cp(cp0),
    .busy(busy0), .done(done0), .err(err0)
  );

  jk_excitation_driver #(.WIDTH(4), .PULSE_CYCLES(P), .DC_FILL(1'b1)) dut_tgl (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_target(req_target), .q_fb(q_fb), .jk_j(j1), .jk_k(k1), .jk_cp(cp1),
    .busy(busy1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  // Excitation table lookup: {j, k} per (q, t) pair, dc on the don't-care input.
  function automatic logic [7:0] model_jk(input logic [3:0] q, input logic [3:0] t,
                                          input logic dc);
    logic [3:0] j, k;
    for (int i = 0; i < 4; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin j[i] = 1'b0; k[i] = dc;   end
        2'b01:   begin j[i] = 1'b1; k[i] = dc;   end
        2'b10:   begin j[i] = dc;   k[i] = 1'b1; end
        default: begin j[i] = dc;   k[i] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  // JK flip-flop characteristic: hold, reset, set, toggle.
  function automatic logic [3:0] bank_next(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00:   n[i] = q[i];
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    end
    return n;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({ctrl0, ctrl1, jkv} !== {5'b10000, 5'b10000, 16'h0}) begin
        errors++;
        $display("FAIL idle: got ctrl %b/%b jk %h expected ctrl 10000/10000 jk 0000",
                 ctrl0, ctrl1, jkv);
      end
    end
  endtask

  // mode 0: hold q_fb, 1: scramble q_fb after accept, 2: q_fb follows bank model,
  // 3: q_fb forced to fval once the pulse has finished.
  task automatic do_request(input logic [3:0] tgt, input logic [3:0] q0, input int mode,
                            input logic [3:0] fval, input bit hold);
    logic [7:0] e0, e1;
    logic [3:0] bank0, bank1, m0, m1, qchk;
    logic [4:0] exp_c;
    logic [15:0] exp_jk;
    bit prev0, prev1, cp_e, exp_err;
    e0 = model_jk(q0, tgt, 1'b0);
    e1 = model_jk(q0, tgt, 1'b1);
    bank0 = q0; bank1 = q0; m0 = q0; m1 = q0;
    prev0 = 1'b0; prev1 = 1'b0;
    qchk = q0;
    @(negedge clk);
    checks++;
    if ({ctrl0, ctrl1} !== {5'b10000, 5'b10000}) begin
      errors++;
      $display("FAIL accept_idle: got %b/%b expected 10000/10000", ctrl0, ctrl1);
    end
    req_valid = 1'b1; req_target = tgt; q_fb = q0;
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      cp_e    = (c >= 2) && (c <= 1 + P);
      exp_err = (V == 1) && (c == L) && (qchk != tgt);
      exp_c   = {1'b0, 1'b1, cp_e, c == L, exp_err};
      exp_jk  = (c <= 1 + P) ? {e0, e1} : 16'h0;
      checks++;
      if ({ctrl0, ctrl1} !== {exp_c, exp_c}) begin
        errors++;
        $display("FAIL ctrl t=%b q=%b cycle %0d: got %b/%b expected %b/%b",
                 tgt, q0, c, ctrl0, ctrl1, exp_c, exp_c);
      end
      checks++;
      if (jkv !== exp_jk) begin
        errors++;
        $display("FAIL jk t=%b q=%b cycle %0d: got %h expected %h", tgt, q0, c, jkv, exp_jk);
      end
      if (cp0) m0 = bank_next(bank0, j0, k0);
      else if (prev0) bank0 = m0;
      if (cp1) m1 = bank_next(bank1, j1, k1);
      else if (prev1) bank1 = m1;
      prev0 = cp0; prev1 = cp1;
      req_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      req_target = 4'($urandom);
      case (mode)
        0:       q_fb = q0;
        1:       q_fb = 4'($urandom);
        2:       q_fb = bank0;
        default: q_fb = (c >= 2 + P) ? fval : q0;
      endcase
      if (c == 2 + 2 * P) qchk = q_fb;
    end
    checks++;
    if ({bank0, bank1} !== {tgt, tgt}) begin
      errors++;
      $display("FAIL bank_result: got %b/%b expected %b/%b", bank0, bank1, tgt, tgt);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl0, ctrl1, jkv} !== 26'h0) begin
      errors++;
      $display("FAIL reset_hold: got %b/%b jk %h expected all 0", ctrl0, ctrl1, jkv);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ready0, busy0, ready1, busy1} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release: got %b expected 1010", {ready0, busy0, ready1, busy1});
    end
  endtask

  task automatic test_basic;
    do_request(4'b0101, 4'b0011, 0, 4'b0000, 1'b0);
    idle_cycles(2);
    do_request(4'b0110, 4'b0110, 0, 4'b0000, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    do_request(4'b1100, 4'b0110, 1, 4'b0000, 1'b1);
    do_request(4'b0011, 4'b1111, 1, 4'b0000, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_verify;
    do_request(4'b0101, 4'b0011, 3, 4'b0100, 1'b0);
    idle_cycles(1);
    do_request(4'b0101, 4'b0011, 2, 4'b0000, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_random;
    bit hold;
    for (int n = 0; n < 24; n++) begin
      hold = 1'($urandom_range(0, 1));
      do_request(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 4'b0000, hold);
      if (!hold) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    req_valid = 1'b1; req_target = 4'b0101; q_fb = 4'b0011;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cp0, cp1} !== 2'b11) begin
      errors++;
      $display("FAIL midop_cp_high: got %b expected 11", {cp0, cp1});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ctrl0, ctrl1, jkv} !== 26'h0) begin
      errors++;
      $display("FAIL midop_reset: got %b/%b jk %h expected all 0", ctrl0, ctrl1, jkv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ready0, busy0, ready1, busy1} !== 4'b1010) begin
      errors++;
      $display("FAIL midop_release: got %b expected 1010", {ready0, busy0, ready1, busy1});
    end
    idle_cycles(2 * L);
    do_request(4'b1010, 4'b0101, 0, 4'b0000, 1'b0);
    idle_cycles(1);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_target = '0; q_fb = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_verify();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
